// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multi-cycle control sequencer.
// Holds the 3-bit state encoding, the decoded instruction-class codes
// and small classification helpers used by the sequencer.
package mc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_BR     = 3'd5;
    localparam state_t S_JMP    = 3'd6;
    localparam state_t S_INT    = 3'd7;

    typedef logic [3:0] ins_class_t;

    localparam ins_class_t IC_ALU    = 4'd0;
    localparam ins_class_t IC_LOAD   = 4'd1;
    localparam ins_class_t IC_STORE  = 4'd2;
    localparam ins_class_t IC_BRANCH = 4'd3;
    localparam ins_class_t IC_JUMP   = 4'd4;
    localparam ins_class_t IC_JAL    = 4'd5;
    localparam ins_class_t IC_ERET   = 4'd6;
    localparam ins_class_t IC_MFC0   = 4'd7;
    localparam ins_class_t IC_MTC0   = 4'd8;
    // 9..15 are reserved and flow through EXEC/WB with no strobes.

    // Classes that pass through S_MEM after S_EXEC.
    function automatic logic needs_mem_stage(input ins_class_t c);
        return (c == IC_LOAD) || (c == IC_STORE) || (c == IC_MFC0) || (c == IC_MTC0);
    endfunction

    // Classes that write a GPR in S_WB.
    function automatic logic writes_gpr_in_wb(input ins_class_t c);
        return (c == IC_ALU) || (c == IC_LOAD) || (c == IC_MFC0);
    endfunction

endpackage

// File: rtl/mc_sequencer_irq_prio_enc.sv
// irq_prio_enc -- lowest-index-wins priority encoder.
// Ports:
//   req_i   : request vector, N bits
//   valid_o : at least one request bit is set
//   idx_o   : index of the lowest set request bit (0 when none set)
module irq_prio_enc #(
    parameter int N = 6,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer -- multi-cycle CPU control sequencer.
// Steps FETCH/DECODE/EXEC/MEM/WB/BR/JMP/INT and decodes the datapath strobes
// from the current state and inputs (no extra output latency). Checks for
// interrupts at instruction completion and aborts stalled memory accesses
// with a bus-error interrupt after MEM_TIMEOUT waiting cycles.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ins_class           : decoded class of the current instruction
//   branch_taken        : branch condition, used in S_BR
//   mem_ready           : memory completes the access this cycle
//   irq, irq_mask, exl  : interrupt requests, enables, CP0 exception level
//   pc_wr .. link       : datapath strobes
//   int_cause           : registered cause code, valid while int_npc=1
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int  N_IRQ       = 6,
    parameter int  MEM_TIMEOUT = 15,
    localparam int CW          = $clog2(N_IRQ + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ins_class,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             exl,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             gpr_wr,
    output logic             dm_wr,
    output logic             mem_req,
    output logic             cp0_wen,
    output logic             int_npc,
    output logic             exl_set,
    output logic             exl_clr,
    output logic             link,
    output logic [CW-1:0]    int_cause
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic [CW-1:0] cause_q, cause_d;

    logic             exl_eff;
    logic [N_IRQ-1:0] pend;
    logic             irq_valid;
    logic [CW-1:0]    irq_idx;
    logic             done;
    logic             bus_err;
    logic             wait_last;

    // ERET leaves the exception level in its S_JMP cycle, so interrupts
    // that were blocked by exl are already visible at its completion.
    assign exl_eff = (state_q == S_JMP && ins_class == IC_ERET) ? 1'b0 : exl;
    assign pend    = irq & irq_mask & ~{N_IRQ{exl_eff}};

    irq_prio_enc #(
        .N (N_IRQ),
        .W (CW)
    ) u_prio (
        .req_i   (pend),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    // This waiting cycle would bring the counter to MEM_TIMEOUT.
    assign wait_last = (wait_q == TIMEOUT_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        done    = 1'b0;
        bus_err = 1'b0;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        gpr_wr  = 1'b0;
        dm_wr   = 1'b0;
        mem_req = 1'b0;
        cp0_wen = 1'b0;
        int_npc = 1'b0;
        exl_set = 1'b0;
        exl_clr = 1'b0;
        link    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (ins_class == IC_BRANCH) begin
                    state_d = S_BR;
                end else if (ins_class == IC_JUMP || ins_class == IC_JAL ||
                             ins_class == IC_ERET) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = needs_mem_stage(ins_class) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (ins_class == IC_LOAD || ins_class == IC_STORE) begin
                    mem_req = 1'b1;
                    dm_wr   = (ins_class == IC_STORE);
                    if (mem_ready) begin
                        if (ins_class == IC_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            done = 1'b1;
                        end
                    end else if (wait_last) begin
                        bus_err = 1'b1;
                    end
                end else if (ins_class == IC_MFC0) begin
                    state_d = S_WB;
                end else begin
                    cp0_wen = (ins_class == IC_MTC0);
                    done    = 1'b1;
                end
            end
            S_WB: begin
                gpr_wr = writes_gpr_in_wb(ins_class);
                done   = 1'b1;
            end
            S_BR: begin
                pc_wr = branch_taken;
                done  = 1'b1;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                gpr_wr  = (ins_class == IC_JAL);
                link    = (ins_class == IC_JAL);
                exl_clr = (ins_class == IC_ERET);
                done    = 1'b1;
            end
            default: begin // S_INT
                pc_wr   = 1'b1;
                int_npc = 1'b1;
                exl_set = 1'b1;
                state_d = S_FETCH;
            end
        endcase

        if (done) begin
            if (irq_valid) begin
                state_d = S_INT;
                cause_d = irq_idx;
            end else begin
                state_d = S_FETCH;
            end
        end

        // A bus error wins over any pending interrupt and ignores exl.
        if (bus_err) begin
            state_d = S_INT;
            cause_d = CW'(N_IRQ);
        end

        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
            wait_d = 8'd0;
        end else if (mem_req && !mem_ready && wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
        end

        // Reset drops every strobe in the same cycle.
        if (rst) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            gpr_wr  = 1'b0;
            dm_wr   = 1'b0;
            mem_req = 1'b0;
            cp0_wen = 1'b0;
            int_npc = 1'b0;
            exl_set = 1'b0;
            exl_clr = 1'b0;
            link    = 1'b0;
        end
    end

    assign int_cause = rst ? '0 : cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer -- directed, table-driven bench for mc_sequencer (N_IRQ=6,
// MEM_TIMEOUT=15). Each vector is one clock: inputs are driven after the
// falling edge and the decoded strobes are compared 1 ns later.
// Strobe vector order: {pc_wr, ir_wr, gpr_wr, dm_wr, mem_req, cp0_wen,
//                       int_npc, exl_set, exl_clr, link}
module tb_mc_sequencer;
    import mc_pkg::*;

    localparam logic [9:0] O_NONE  = 10'b0000000000;
    localparam logic [9:0] O_FOK   = 10'b1100100000; // fetch completes
    localparam logic [9:0] O_MREQ  = 10'b0000100000; // fetch waiting
    localparam logic [9:0] O_ST    = 10'b0001100000; // store access
    localparam logic [9:0] O_GPR   = 10'b0010000000;
    localparam logic [9:0] O_PC    = 10'b1000000000;
    localparam logic [9:0] O_JAL   = 10'b1010000001;
    localparam logic [9:0] O_ERET  = 10'b1000000010;
    localparam logic [9:0] O_CP0   = 10'b0000010000;
    localparam logic [9:0] O_INT   = 10'b1000001100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ins_class = 4'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] irq = 6'd0;
    logic [5:0] irq_mask = 6'd0;
    logic       exl = 1'b0;
    logic       pc_wr, ir_wr, gpr_wr, dm_wr, mem_req, cp0_wen;
    logic       int_npc, exl_set, exl_clr, link;
    logic [2:0] int_cause;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_sequencer #(
        .N_IRQ       (6),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_class    (ins_class),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .exl          (exl),
        .pc_wr        (pc_wr),
        .ir_wr        (ir_wr),
        .gpr_wr       (gpr_wr),
        .dm_wr        (dm_wr),
        .mem_req      (mem_req),
        .cp0_wen      (cp0_wen),
        .int_npc      (int_npc),
        .exl_set      (exl_set),
        .exl_clr      (exl_clr),
        .link         (link),
        .int_cause    (int_cause)
    );

    typedef struct {
        logic       r;
        logic [3:0] cls;
        logic       bt;
        logic       rdy;
        logic [5:0] iq;
        logic [5:0] mk;
        logic       ex;
        logic [9:0] exp_o;
        logic [2:0] exp_c;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] cls, input logic bt,
                       input logic rdy, input logic [5:0] iq, input logic [5:0] mk,
                       input logic ex, input logic [9:0] exp_o, input logic [2:0] exp_c,
                       input string nm);
        vec_t v;
        v.r = r; v.cls = cls; v.bt = bt; v.rdy = rdy; v.iq = iq; v.mk = mk;
        v.ex = ex; v.exp_o = exp_o; v.exp_c = exp_c; v.nm = nm;
        tbl.push_back(v);
    endtask

    // One clock: drive, settle, compare. int_cause is checked when it is
    // defined to be valid (int_npc expected) and during reset.
    task automatic step(input logic r, input logic [3:0] cls, input logic bt,
                        input logic rdy, input logic [5:0] iq, input logic [5:0] mk,
                        input logic ex, input logic [9:0] exp_o, input logic [2:0] exp_c,
                        input string nm);
        logic [9:0] act;
        @(negedge clk);
        rst = r; ins_class = cls; branch_taken = bt; mem_ready = rdy;
        irq = iq; irq_mask = mk; exl = ex;
        #1;
        act = {pc_wr, ir_wr, gpr_wr, dm_wr, mem_req, cp0_wen,
               int_npc, exl_set, exl_clr, link};
        n_vec++;
        if (act !== exp_o || ((exp_o[3] || r) && int_cause !== exp_c)) begin
            n_err++;
            $display("FAIL %s: got strobes=%b cause=%0d, expected strobes=%b cause=%0d",
                     nm, act, int_cause, exp_o, exp_c);
        end else begin
            $display("ok   %s: strobes=%b cause=%0d", nm, act, int_cause);
        end
    endtask

    initial begin
        // ---------------- table: one row per cycle ----------------
        add(1, IC_ALU,    0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "reset");
        add(0, IC_ALU,    0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "alu_fetch");
        add(0, IC_ALU,    0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "alu_decode");
        add(0, IC_ALU,    0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "alu_exec");
        add(0, IC_ALU,    0, 1, 6'h00, 6'h00, 0, O_GPR,  0, "alu_wb");
        add(0, IC_LOAD,   0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "ld_fetch");
        add(0, IC_LOAD,   0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "ld_decode");
        add(0, IC_LOAD,   0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "ld_exec");
        add(0, IC_LOAD,   0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "ld_mem_w1");
        add(0, IC_LOAD,   0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "ld_mem_w2");
        add(0, IC_LOAD,   0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "ld_mem_w3");
        add(0, IC_LOAD,   0, 1, 6'h00, 6'h00, 0, O_MREQ, 0, "ld_mem_rdy");
        add(0, IC_LOAD,   0, 1, 6'h00, 6'h00, 0, O_GPR,  0, "ld_wb");
        add(0, IC_STORE,  0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "st_fetch");
        add(0, IC_STORE,  0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "st_decode");
        add(0, IC_STORE,  0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "st_exec");
        add(0, IC_STORE,  0, 1, 6'h00, 6'h00, 0, O_ST,   0, "st_mem");
        add(0, IC_BRANCH, 1, 1, 6'h00, 6'h00, 0, O_FOK,  0, "bt_fetch");
        add(0, IC_BRANCH, 1, 1, 6'h00, 6'h00, 0, O_NONE, 0, "bt_decode");
        add(0, IC_BRANCH, 1, 1, 6'h00, 6'h00, 0, O_PC,   0, "bt_br_taken");
        add(0, IC_BRANCH, 0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "bn_fetch");
        add(0, IC_BRANCH, 0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "bn_decode");
        add(0, IC_BRANCH, 0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "bn_br_not");
        add(0, IC_JAL,    0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "jal_fetch");
        add(0, IC_JAL,    0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "jal_decode");
        add(0, IC_JAL,    0, 1, 6'h00, 6'h00, 0, O_JAL,  0, "jal_jmp");
        add(0, IC_MFC0,   0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "mfc0_fetch");
        add(0, IC_MFC0,   0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "mfc0_decode");
        add(0, IC_MFC0,   0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "mfc0_exec");
        add(0, IC_MFC0,   0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "mfc0_mem");
        add(0, IC_MFC0,   0, 1, 6'h00, 6'h00, 0, O_GPR,  0, "mfc0_wb");
        add(0, IC_MTC0,   0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "mtc0_fetch");
        add(0, IC_MTC0,   0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "mtc0_decode");
        add(0, IC_MTC0,   0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "mtc0_exec");
        add(0, IC_MTC0,   0, 1, 6'h00, 6'h00, 0, O_CP0,  0, "mtc0_mem");
        add(0, 4'd12,     0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "rsv_fetch");
        add(0, 4'd12,     0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "rsv_decode");
        add(0, 4'd12,     0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "rsv_exec");
        add(0, 4'd12,     0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "rsv_wb");
        add(0, IC_ALU,    0, 1, 6'b010100, 6'b111100, 0, O_FOK,  0, "irq_fetch");
        add(0, IC_ALU,    0, 1, 6'b010100, 6'b111100, 0, O_NONE, 0, "irq_decode");
        add(0, IC_ALU,    0, 1, 6'b010100, 6'b111100, 0, O_NONE, 0, "irq_exec");
        add(0, IC_ALU,    0, 1, 6'b010100, 6'b111100, 0, O_GPR,  0, "irq_wb");
        add(0, IC_ALU,    0, 1, 6'b010100, 6'b111100, 0, O_INT,  2, "irq_int");
        add(0, IC_ERET,   0, 1, 6'b000001, 6'b000001, 1, O_FOK,  0, "eret_fetch");
        add(0, IC_ERET,   0, 1, 6'b000001, 6'b000001, 1, O_NONE, 0, "eret_decode");
        add(0, IC_ERET,   0, 1, 6'b000001, 6'b000001, 1, O_ERET, 0, "eret_jmp");
        add(0, IC_ERET,   0, 1, 6'b000001, 6'b000001, 1, O_INT,  0, "eret_int");
        add(0, IC_JUMP,   0, 1, 6'b000001, 6'b000001, 1, O_FOK,  0, "jmp_fetch");
        add(0, IC_JUMP,   0, 1, 6'b000001, 6'b000001, 1, O_NONE, 0, "jmp_decode");
        add(0, IC_JUMP,   0, 1, 6'b000001, 6'b000001, 1, O_PC,   0, "jmp_jmp");
        add(0, IC_JUMP,   0, 0, 6'b000001, 6'b000001, 1, O_MREQ, 0, "jmp_next_fetch");
        add(0, IC_ALU,    0, 1, 6'b000010, 6'b000001, 0, O_FOK,  0, "mask_fetch");
        add(0, IC_ALU,    0, 1, 6'b000010, 6'b000001, 0, O_NONE, 0, "mask_decode");
        add(0, IC_ALU,    0, 1, 6'b000010, 6'b000001, 0, O_NONE, 0, "mask_exec");
        add(0, IC_ALU,    0, 1, 6'b000010, 6'b000001, 0, O_GPR,  0, "mask_wb");
        add(0, IC_ALU,    0, 0, 6'b000010, 6'b000001, 0, O_MREQ, 0, "mask_next_fetch");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].cls, tbl[i].bt, tbl[i].rdy, tbl[i].iq, tbl[i].mk,
                 tbl[i].ex, tbl[i].exp_o, tbl[i].exp_c, tbl[i].nm);
        end

        // ------- store never ready: bus error beats a pending irq0 -------
        step(1, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "to_reset");
        step(0, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "to_fetch");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "to_decode");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "to_exec");
        for (int k = 0; k < 15; k++) begin
            step(0, IC_STORE, 0, 0, 6'b000001, 6'b000001, 0, O_ST, 0, "to_mem_stall");
        end
        step(0, IC_STORE, 0, 0, 6'b000001, 6'b000001, 0, O_INT,  6, "to_buserr_int");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "to_after_fetch");

        // ------- ready arrives in the last allowed cycle: no bus error -------
        step(1, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "edge_reset");
        step(0, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "edge_fetch");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "edge_decode");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "edge_exec");
        for (int k = 0; k < 14; k++) begin
            step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_ST, 0, "edge_mem_stall");
        end
        step(0, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_ST,   0, "edge_mem_rdy");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "edge_next_fetch");

        // ------- reset pulse mid-store, then fetch timeout from a clean counter -------
        step(1, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_NONE, 0, "rp_reset");
        step(0, IC_STORE, 0, 1, 6'h00, 6'h00, 0, O_FOK,  0, "rp_fetch");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "rp_decode");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "rp_exec");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_ST,   0, "rp_mem_w1");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_ST,   0, "rp_mem_w2");
        step(1, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_NONE, 0, "rp_rst_pulse");
        for (int k = 0; k < 15; k++) begin
            step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "rp_fetch_stall");
        end
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_INT,  6, "rp_fetch_buserr");
        step(0, IC_STORE, 0, 0, 6'h00, 6'h00, 0, O_MREQ, 0, "rp_after_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter N_IRQ, default 6: number of interrupt lines, range 1..31.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum cycles to wait for mem_ready, range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port ins_class, input, 4: decoded class of the current IR (encoding per REQ-033); held stable from DECODE to instruction completion.
REQ-006 Port branch_taken, input, 1: branch condition true; sampled in S_BR.
REQ-007 Port mem_ready, input, 1: memory/bridge completes the access this cycle; ignored while mem_req=0.
REQ-008 Port irq, input, N_IRQ: level interrupt requests.
REQ-009 Port irq_mask, input, N_IRQ: interrupt enables, from CP0.
REQ-010 Port exl, input, 1: CP0 exception level; 1 blocks interrupts.
REQ-011 Ports pc_wr, ir_wr, gpr_wr, dm_wr, mem_req, cp0_wen, int_npc, exl_set, exl_clr, link: output, 1 each: datapath strobes.
REQ-012 Port int_cause, output, CW=$clog2(N_IRQ+1): registered cause code, valid while int_npc=1.

Function
REQ-013 States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_JMP, S_INT; all outputs are decoded from state and inputs, with no output latency beyond the state register.
REQ-014 S_FETCH: mem_req=1; on mem_ready=1, ir_wr=1 and pc_wr=1 for that cycle, then go to S_DECODE; otherwise stay.
REQ-015 S_DECODE (1 cycle): BRANCH goes to S_BR; JUMP, JAL and ERET go to S_JMP; all others go to S_EXEC.
REQ-016 S_EXEC (1 cycle): LOAD, STORE, MFC0 and MTC0 go to S_MEM; all others go to S_WB.
REQ-017 S_MEM, LOAD/STORE: mem_req=1, and dm_wr=1 for STORE only; stay until mem_ready. On mem_ready, LOAD goes to S_WB and STORE completes.
REQ-018 S_MEM, MFC0: 1 cycle, then S_WB. S_MEM, MTC0: cp0_wen=1 for 1 cycle, then completes.
REQ-019 S_WB: gpr_wr=1 for ALU, LOAD and MFC0; gpr_wr=0 for reserved classes; 1 cycle, then completes.
REQ-020 S_BR: pc_wr=branch_taken; 1 cycle, then completes.
REQ-021 S_JMP: pc_wr=1 for 1 cycle, then completes. JAL additionally asserts gpr_wr=1 and link=1. ERET additionally asserts exl_clr=1.
REQ-022 Completion check: pend = irq & irq_mask & ~{N_IRQ{exl_eff}}. exl_eff=0 in the S_JMP cycle of ERET; otherwise exl_eff=exl. If |pend, go to S_INT; else go to S_FETCH.
REQ-023 Interrupt priority: the lowest set index of pend wins; int_cause is registered with that index on entry to S_INT.
REQ-024 Wait counter: cleared on entry to any state that asserts mem_req, incremented each cycle mem_req=1 and mem_ready=0, saturating at 8 bits.
REQ-025 Bus error: if the counter reaches MEM_TIMEOUT with mem_ready=0, abort the access. No ir_wr, dm_wr or gpr_wr results; next state is S_INT with int_cause=N_IRQ. Bus error overrides any pending irq.
REQ-026 mem_ready in the same cycle the counter reaches MEM_TIMEOUT: the access completes normally and no bus error is raised.
REQ-027 S_INT (1 cycle): pc_wr=1, int_npc=1, exl_set=1, then S_FETCH. Bus error is taken regardless of exl.
REQ-028 Reserved ins_class codes follow the path S_DECODE -> S_EXEC -> S_WB with all strobes 0.

Reset
REQ-029 While rst=1, state is forced to S_FETCH, the counter and int_cause are cleared to 0, and every output is held at 0, including mem_req.
REQ-030 When rst is asserted mid-instruction, pending strobes are dropped in the same cycle; after rst deasserts, mem_req=1 on the first cycle.

Structure
REQ-031 The shared package mc_pkg holds the state encoding (3-bit localparams) and the ins_class codes.
REQ-032 One sub-module, irq_prio_enc: parametrised lowest-index priority encoder returning a valid flag and an index.
REQ-033 ins_class encoding: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JAL, 6 ERET, 7 MFC0, 8 MTC0; 9-15 reserved.

Verification
REQ-034 ALU with mem_ready always 1 -> 4 cycles FETCH/DECODE/EXEC/WB; gpr_wr=1 only in cycle 4.
REQ-035 LOAD with mem_ready delayed 3 cycles in S_MEM -> mem_req high for exactly 4 S_MEM cycles, then gpr_wr=1 one cycle later.
REQ-036 STORE with mem_ready never asserted, MEM_TIMEOUT=15 -> dm_wr high for 15 cycles then drops; S_INT follows with int_cause=6 (N_IRQ=6) and no gpr_wr.
REQ-037 ALU in progress with irq=6'b010100, irq_mask=6'b111100, exl=0 -> after WB, S_INT with int_cause=2, exl_set=1, pc_wr=1.
REQ-038 ERET with exl=1 and irq[0]=mask[0]=1 -> exl_clr=1 in S_JMP, next state S_INT with int_cause=0; same case with JUMP -> next state S_FETCH.
REQ-039 rst pulsed for 1 cycle during S_MEM of a STORE -> dm_wr=0 in that cycle; next cycle state is S_FETCH with mem_req=1 and counter=0.
